// File: rtl/seed_random_1_card_receiver_pkg.sv
// Shared types for the card receiver: FSM states, deck constants, card type.
// Pure declarations; no logic, no latency.
package seed_random_1_card_receiver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CHECK,
        DONE
    } state_t;

    localparam int         DECK_SIZE    = 52;
    localparam logic [7:0] CARD_INVALID = 8'hFF;

    typedef logic [7:0] card_t;

endpackage

// File: rtl/seed_random_1_data_path.sv
// Card source stage: presents the externally supplied card only in the cycle after a request.
// Latency: card valid one cycle after req_card_state_dp_i; outside that window it reads CARD_INVALID.
// No backpressure: one request in flight at a time, enforced by the receiver FSM.
module seed_random_1_data_path
    import seed_random_1_card_receiver_pkg::*;
(
    input  logic  clk_dp_i,
    input  logic  rst_dp_i,
    input  logic  req_card_state_dp_i,
    input  card_t card_src_dp_i,
    output card_t card_to_send_dp_o
);

    logic pending;

    always_ff @(posedge clk_dp_i or posedge rst_dp_i) begin
        if (rst_dp_i) begin
            pending <= 1'b0;
        end else begin
            pending <= req_card_state_dp_i;
        end
    end

    assign card_to_send_dp_o = pending ? card_src_dp_i : CARD_INVALID;

endmodule

// File: rtl/seed_random_1_deck_tracker.sv
// Tracks which of the 52 cards are dealt, judges card validity and counts cards left.
// Latency: validity is combinational; mask/count update on the commit or clear edge.
// No backpressure: clear and commit are single-cycle strobes from the receiver FSM.
module seed_random_1_deck_tracker
    import seed_random_1_card_receiver_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       commit,
    input  card_t      card,
    output logic       valid,
    output logic [5:0] cards_left
);

    logic [DECK_SIZE-1:0] used;
    logic                 in_range;

    assign in_range = (card < 8'(DECK_SIZE));
    assign valid    = in_range && !used[card[5:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used       <= '0;
            cards_left <= 6'(DECK_SIZE);
        end else if (clear) begin
            used       <= '0;
            cards_left <= 6'(DECK_SIZE);
        end else if (commit) begin
            used[card[5:0]] <= 1'b1;
            cards_left      <= cards_left - 6'd1;
        end
    end

endmodule

// File: rtl/seed_random_1_card_receiver.sv
// Deals a hand by requesting cards from the data path and keeping only unused deck cards.
// Latency: one request every 3 cycles (REQ, WAIT, CHECK); hand_done pulses one cycle after the last card.
// No backpressure: deal/clear requests arriving while busy are dropped.
module seed_random_1_card_receiver
    import seed_random_1_card_receiver_pkg::*;
#(
    parameter int HAND_MAX  = 5,
    parameter int RETRY_MAX = 15
) (
    input  logic       clk_cr_i,
    input  logic       rst_cr_i,
    input  logic       deal_start_cr_i,
    input  logic [2:0] hand_size_cr_i,
    input  logic       deck_clear_cr_i,
    input  logic [7:0] card_to_send_cr_i,
    output logic       req_card_state_cr_o,
    input  logic [2:0] rd_idx_cr_i,
    output logic [7:0] rd_card_cr_o,
    output logic       busy_cr_o,
    output logic       hand_done_cr_o,
    output logic       error_cr_o,
    output logic [5:0] cards_left_cr_o
);

    localparam int RW = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);

    state_t        state, state_next;
    logic [2:0]    size_q, count_q;
    logic [RW-1:0] retry_q;
    logic          error_q;
    card_t         card_q;
    card_t         card_from_dp;
    card_t         slots [HAND_MAX];

    logic       size_ok, accept, bad_size, commit, reject, fail, deck_clear;
    logic       card_valid;
    logic [5:0] cards_left;

    seed_random_1_data_path u_data_path (
        .clk_dp_i            (clk_cr_i),
        .rst_dp_i            (rst_cr_i),
        .req_card_state_dp_i (req_card_state_cr_o),
        .card_src_dp_i       (card_to_send_cr_i),
        .card_to_send_dp_o   (card_from_dp)
    );

    seed_random_1_deck_tracker u_deck_tracker (
        .clk        (clk_cr_i),
        .rst        (rst_cr_i),
        .clear      (deck_clear),
        .commit     (commit),
        .card       (card_q),
        .valid      (card_valid),
        .cards_left (cards_left)
    );

    assign size_ok = (hand_size_cr_i != 3'd0) && (int'(hand_size_cr_i) <= HAND_MAX);

    // An empty deck is routed through CHECK so the error is raised without a request pulse.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        bad_size   = 1'b0;
        commit     = 1'b0;
        reject     = 1'b0;
        fail       = 1'b0;
        deck_clear = 1'b0;
        case (state)
            IDLE: begin
                deck_clear = deck_clear_cr_i;
                if (deal_start_cr_i) begin
                    if (size_ok) begin
                        accept     = 1'b1;
                        state_next = (cards_left == 6'd0 && !deck_clear_cr_i) ? CHECK : REQ;
                    end else begin
                        bad_size = 1'b1;
                    end
                end
            end
            REQ:  state_next = WAIT;
            WAIT: state_next = CHECK;
            CHECK: begin
                if (cards_left == 6'd0) begin
                    fail       = 1'b1;
                    state_next = IDLE;
                end else if (card_valid) begin
                    commit = 1'b1;
                    if (count_q + 3'd1 == size_q) begin
                        state_next = DONE;
                    end else if (cards_left == 6'd1) begin
                        state_next = CHECK;
                    end else begin
                        state_next = REQ;
                    end
                end else begin
                    reject = 1'b1;
                    if (retry_q == RW'(RETRY_MAX - 1)) begin
                        fail       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_cr_i or posedge rst_cr_i) begin
        if (rst_cr_i) begin
            state   <= IDLE;
            size_q  <= 3'd0;
            count_q <= 3'd0;
            retry_q <= '0;
            error_q <= 1'b0;
            card_q  <= CARD_INVALID;
            for (int i = 0; i < HAND_MAX; i++) begin
                slots[i] <= CARD_INVALID;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                size_q  <= hand_size_cr_i;
                count_q <= 3'd0;
                retry_q <= '0;
                error_q <= 1'b0;
            end
            if (bad_size || fail) begin
                error_q <= 1'b1;
            end
            if (state == WAIT) begin
                card_q <= card_from_dp;
            end
            if (commit) begin
                slots[count_q] <= card_q;
                count_q        <= count_q + 3'd1;
                retry_q        <= '0;
            end
            if (reject) begin
                retry_q <= retry_q + RW'(1);
            end
        end
    end

    assign req_card_state_cr_o = (state == REQ);
    assign hand_done_cr_o      = (state == DONE);
    assign busy_cr_o           = (state != IDLE);
    assign error_cr_o          = error_q;
    assign cards_left_cr_o     = cards_left;
    assign rd_card_cr_o        = (int'(rd_idx_cr_i) < HAND_MAX) ? slots[rd_idx_cr_i] : CARD_INVALID;

endmodule

// File: tb/tb_seed_random_1_card_receiver.sv
// Directed bench for the card receiver with a scripted card source answering each request.
module tb_seed_random_1_card_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       deal_start = 1'b0;
    logic [2:0] hand_size = 3'd0;
    logic       deck_clear = 1'b0;
    logic [7:0] card_in = 8'hFF;
    logic       req;
    logic [2:0] rd_idx = 3'd0;
    logic [7:0] rd_card;
    logic       busy;
    logic       hand_done;
    logic       error;
    logic [5:0] cards_left;

    int errors = 0;
    int checks = 0;

    logic [7:0] script [0:63];
    int script_len = 0;
    int base = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    int req_mark;
    int done_mark;

    seed_random_1_card_receiver #(.HAND_MAX(5), .RETRY_MAX(15)) dut (
        .clk_cr_i            (clk),
        .rst_cr_i            (rst),
        .deal_start_cr_i     (deal_start),
        .hand_size_cr_i      (hand_size),
        .deck_clear_cr_i     (deck_clear),
        .card_to_send_cr_i   (card_in),
        .req_card_state_cr_o (req),
        .rd_idx_cr_i         (rd_idx),
        .rd_card_cr_o        (rd_card),
        .busy_cr_o           (busy),
        .hand_done_cr_o      (hand_done),
        .error_cr_o          (error),
        .cards_left_cr_o     (cards_left)
    );

    always #5 clk = ~clk;

    // Card source: answers each request with the next scripted card, 200 once the script runs out.
    always @(negedge clk) begin
        int idx;
        if (req) begin
            idx = req_cnt - base;
            card_in = (idx < script_len) ? script[idx] : 8'd200;
            req_cnt = req_cnt + 1;
        end
        if (hand_done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_deal(input logic [2:0] size, input logic clr);
        deal_start = 1'b1;
        deck_clear = clr;
        hand_size  = size;
        tick(1);
        deal_start = 1'b0;
        deck_clear = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && busy; i++) tick(1);
        check(tag, busy, 0);
    endtask

    task automatic read_slot(input string tag, input logic [2:0] idx, input logic [7:0] exp);
        rd_idx = idx;
        #1;
        check(tag, rd_card, exp);
    endtask

    task automatic mark();
        base      = req_cnt;
        req_mark  = req_cnt;
        done_mark = done_cnt;
    endtask

    initial begin
        // Reset state
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_req", req, 0);
        check("rst_done", hand_done, 0);
        check("rst_error", error, 0);
        check("rst_cards_left", cards_left, 52);
        read_slot("rst_slot0", 3'd0, 8'hFF);
        rst = 1'b0;
        tick(1);

        // Hand of 5 with distinct cards; a clear and a deal during the hand are ignored
        mark();
        script[0] = 8'd3; script[1] = 8'd17; script[2] = 8'd40; script[3] = 8'd8; script[4] = 8'd51;
        script_len = 5;
        start_deal(3'd5, 1'b0);
        check("t1_busy", busy, 1);
        tick(2);
        start_deal(3'd1, 1'b1);
        wait_idle("t1_idle");
        check("t1_pulses", req_cnt - req_mark, 5);
        check("t1_done", done_cnt - done_mark, 1);
        check("t1_cards_left", cards_left, 47);
        check("t1_error", error, 0);
        read_slot("t1_slot0", 3'd0, 8'd3);
        read_slot("t1_slot1", 3'd1, 8'd17);
        read_slot("t1_slot2", 3'd2, 8'd40);
        read_slot("t1_slot3", 3'd3, 8'd8);
        read_slot("t1_slot4", 3'd4, 8'd51);
        read_slot("t1_slot5_oob", 3'd5, 8'hFF);
        read_slot("t1_slot7_oob", 3'd7, 8'hFF);

        // Duplicate and out-of-range cards are rejected
        mark();
        script[0] = 8'd9; script[1] = 8'd9; script[2] = 8'd60; script[3] = 8'd22;
        script_len = 4;
        start_deal(3'd2, 1'b0);
        wait_idle("t2_idle");
        check("t2_pulses", req_cnt - req_mark, 4);
        check("t2_error", error, 0);
        check("t2_cards_left", cards_left, 45);
        read_slot("t2_slot0", 3'd0, 8'd9);
        read_slot("t2_slot1", 3'd1, 8'd22);
        read_slot("t2_slot2_kept", 3'd2, 8'd40);

        // Endless invalid card exhausts the retry budget
        mark();
        script_len = 0;
        start_deal(3'd3, 1'b0);
        wait_idle("t3_idle");
        check("t3_pulses", req_cnt - req_mark, 15);
        check("t3_error", error, 1);
        check("t3_done", done_cnt - done_mark, 0);
        check("t3_cards_left", cards_left, 45);

        // Clear together with deal: clear first, deal uses the fresh deck, error cleared
        mark();
        script[0] = 8'd7;
        script_len = 1;
        start_deal(3'd1, 1'b1);
        wait_idle("t4_clr_idle");
        check("t4_clr_error", error, 0);
        check("t4_clr_cards_left", cards_left, 51);
        read_slot("t4_clr_slot0", 3'd0, 8'd7);

        // Out-of-range hand sizes
        mark();
        script[0] = 8'd12;
        script_len = 1;
        start_deal(3'd1, 1'b0);
        wait_idle("t4_a_idle");
        check("t4_a_error", error, 0);
        start_deal(3'd0, 1'b0);
        check("t4_size0_busy", busy, 0);
        check("t4_size0_error", error, 1);
        mark();
        script[0] = 8'd13;
        script_len = 1;
        start_deal(3'd1, 1'b0);
        wait_idle("t4_b_idle");
        check("t4_b_error", error, 0);
        start_deal(3'd6, 1'b0);
        check("t4_size6_busy", busy, 0);
        check("t4_size6_error", error, 1);
        tick(3);
        check("t4_size6_busy_later", busy, 0);
        check("t4_cards_left", cards_left, 49);

        // Reset while waiting for the 3rd card
        mark();
        script[0] = 8'd30; script[1] = 8'd31; script[2] = 8'd32; script[3] = 8'd33; script[4] = 8'd34;
        script_len = 5;
        start_deal(3'd5, 1'b0);
        for (int i = 0; i < 100 && (req_cnt - base) < 3; i++) begin
            @(posedge clk);
        end
        check("t5_reached_third", req_cnt - base, 3);
        #1;
        rst = 1'b1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_req", req, 0);
        check("t5_done", hand_done, 0);
        check("t5_error", error, 0);
        check("t5_cards_left", cards_left, 52);
        read_slot("t5_slot0", 3'd0, 8'hFF);
        read_slot("t5_slot1", 3'd1, 8'hFF);
        tick(1);
        rst = 1'b0;
        tick(10);
        check("t5_no_more_pulses", req_cnt - req_mark, 3);
        check("t5_idle_after", busy, 0);

        // Deal the whole deck, then one more deal on the empty deck
        mark();
        for (int i = 0; i < 52; i++) script[i] = 8'(i);
        script_len = 52;
        for (int h = 0; h < 10; h++) begin
            start_deal(3'd5, 1'b0);
            wait_idle("t6_hand_idle");
        end
        start_deal(3'd2, 1'b0);
        wait_idle("t6_last_idle");
        check("t6_pulses", req_cnt - req_mark, 52);
        check("t6_done", done_cnt - done_mark, 11);
        check("t6_cards_left", cards_left, 0);
        check("t6_error", error, 0);
        read_slot("t6_slot1", 3'd1, 8'd51);
        read_slot("t6_slot4", 3'd4, 8'd49);
        mark();
        start_deal(3'd3, 1'b0);
        wait_idle("t6_empty_idle");
        check("t6_empty_error", error, 1);
        check("t6_empty_pulses", req_cnt - req_mark, 0);
        check("t6_empty_done", done_cnt - done_mark, 0);
        deck_clear = 1'b1;
        tick(1);
        deck_clear = 1'b0;
        check("t6_clear_cards_left", cards_left, 52);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seed_random_1_card_receiver.md
SEED_RANDOM_1_CARD_RECEIVER -- requirements
Module: seed_random_1_card_receiver

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is asynchronous and active-high, and the ports are named clk_cr_i and rst_cr_i.
REQ-002 Parameter HAND_MAX, default 5, SHALL set the maximum cards held in one hand.
REQ-003 Parameter RETRY_MAX, default 15, SHALL set the number of consecutive rejected cards tolerated before an error.
REQ-004 Port clk_cr_i  input  1  SHALL be the system clock; all state changes on its rising edge.
REQ-005 Port rst_cr_i  input  1  SHALL be the asynchronous active-high reset.
REQ-006 Port deal_start_cr_i  input  1  SHALL be a one-cycle request to deal a new hand.
REQ-007 Port hand_size_cr_i  input  3  SHALL be the number of cards to deal, sampled when deal_start_cr_i is accepted.
REQ-008 Port deck_clear_cr_i  input  1  SHALL clear the used-card record, which is only accepted in IDLE.
REQ-009 Port card_to_send_cr_i  input  8  SHALL be the card value returned by the data path.
REQ-010 Port req_card_state_cr_o  output  1  SHALL be the one-cycle card request pulse sent to the data path.
REQ-011 Port rd_idx_cr_i  input  3  SHALL select the hand slot for readback.
REQ-012 Port rd_card_cr_o  output  8  SHALL be the combinational readback of the selected slot, and 8'hFF if rd_idx_cr_i >= HAND_MAX.
REQ-013 Port busy_cr_o  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-014 Port hand_done_cr_o  output  1  SHALL be a one-cycle pulse when the hand is complete.
REQ-015 Port error_cr_o  output  1  SHALL be a sticky error flag, cleared by the next accepted deal_start_cr_i or by reset.
REQ-016 Port cards_left_cr_o  output  6  SHALL be the count of unused deck cards, from 52 down to 0.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, REQ, WAIT, CHECK, DONE.
REQ-018 In IDLE, deal_start_cr_i with 1 <= hand_size_cr_i <= HAND_MAX SHALL:
- latch the size;
- clear the slot count, the retry count and error_cr_o;
- go to REQ.
REQ-019 In IDLE, deal_start_cr_i with an out-of-range size SHALL set error_cr_o and remain in IDLE.
REQ-020 REQ SHALL assert req_card_state_cr_o for exactly one cycle, then go to WAIT.
REQ-021 WAIT SHALL register card_to_send_cr_i one cycle after the request pulse, then go to CHECK.
REQ-022 A card SHALL be valid iff its value is 0..51 and its bit in the 52-bit used mask is clear.
REQ-023 In CHECK, a valid card SHALL:
- be written to the slot at the current count;
- set its used bit;
- decrement cards_left_cr_o;
- increment the count and clear the retry count;
- go to DONE if count+1 equals the latched size, otherwise to REQ.
REQ-024 In CHECK, an invalid card SHALL increment the retry count and go to REQ.
REQ-025 In CHECK, when the retry count reaches RETRY_MAX, the block SHALL set error_cr_o and go to IDLE.
REQ-026 In CHECK, if cards_left_cr_o is 0, the block SHALL set error_cr_o and go to IDLE without issuing a request.
REQ-027 DONE SHALL pulse hand_done_cr_o for one cycle, then go to IDLE.
REQ-028 deal_start_cr_i while busy SHALL be ignored.
REQ-029 deck_clear_cr_i while busy SHALL be ignored.
REQ-030 deck_clear_cr_i and deal_start_cr_i asserted together in IDLE SHALL apply the clear first, and the deal then uses the cleared deck.
REQ-031 Consecutive request pulses SHALL be at least 3 cycles apart (REQ, WAIT, CHECK).
REQ-032 Hand slots SHALL retain their contents until overwritten by a later deal.

Reset
REQ-033 Reset SHALL set:
- FSM = IDLE;
- used mask = 0 and cards_left_cr_o = 52;
- all slots = 8'hFF;
- slot count and retry count = 0;
- req_card_state_cr_o, hand_done_cr_o, busy_cr_o and error_cr_o = 0.
REQ-034 Reset asserted mid-deal SHALL abort immediately with no further request pulse, and the partial hand SHALL be lost.

Structure
REQ-035 A shared package SHALL hold:
- the FSM state enum;
- DECK_SIZE = 52;
- CARD_INVALID = 8'hFF;
- the 8-bit card typedef.
REQ-036 The used-mask, validity check and cards-left counter SHALL be one sub-module, seed_random_1_deck_tracker.
REQ-037 The top SHALL instantiate seed_random_1_data_path with req_card_state_cr_o connected to req_card_state_dp_i and card_to_send_dp_o connected to card_to_send_cr_i.

Verification
REQ-038 The bench SHALL cover, each with a scripted card model:
- Reset, then deal with hand_size 5 and cards 3,17,40,8,51 -> exactly 5 request pulses; rd_card_cr_o for slots 0..4 reads 3,17,40,8,51; one hand_done_cr_o pulse; cards_left_cr_o = 47.
- Cards 9,9,60,22 with hand_size 2 -> 9 and 22 stored; 4 request pulses; error_cr_o = 0.
- Card 200 repeated -> error_cr_o set after 15 rejections; FSM returns to IDLE; no hand_done_cr_o.
- deal_start_cr_i with hand_size 0, and again with 6 -> error_cr_o = 1; busy_cr_o stays 0.
- Reset during WAIT of the 3rd card -> outputs take their reset values; slots read 8'hFF; cards_left_cr_o = 52.
- Deal 52 unique cards across hands, then deal again -> error_cr_o = 1 with 0 further request pulses; after deck_clear_cr_i, cards_left_cr_o = 52.
